// File: rtl/shift_cmd_stage_if.sv
// Command and result handshake bundle for shift_cmd_stage.
// The slave modport is the stage's view; the master modport is the producer/consumer side.
interface shift_cmd_stage_if #(
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_data;
    logic [4:0]       cmd_amount;
    logic             cmd_dir;
    logic             cmd_type;
    logic [TAG_W-1:0] cmd_tag;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;

    modport master (
        output cmd_valid, cmd_data, cmd_amount, cmd_dir, cmd_type, cmd_tag, res_ready,
        input  cmd_ready, res_valid, res_data, res_tag
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_amount, cmd_dir, cmd_type, cmd_tag, res_ready,
        output cmd_ready, res_valid, res_data, res_tag
    );
endinterface

// File: rtl/shift_cmd_stage.sv
// Command FIFO + result register around the combinational Shifter32.
// Optional macro SHIFT_STATS_EN adds saturating issue/stall counters (stat_issued, stat_stall).
module shift_cmd_stage #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    shift_cmd_stage_if.slave         bus,
    output logic [31:0]              sh_data_in,
    output logic [4:0]               sh_shift_amount,
    output logic                     sh_shift_direction,
    output logic                     sh_shift_type,
    input  logic [31:0]              sh_data_out,
    output logic [$clog2(DEPTH):0]   count
`ifdef SHIFT_STATS_EN
    ,
    output logic [15:0]              stat_issued,
    output logic [15:0]              stat_stall
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0]      data;
        logic [4:0]       amount;
        logic             dir;
        logic             typ;
        logic [TAG_W-1:0] tag;
    } entry_t;

    typedef enum logic {ST_EMPTY, ST_HOLD} state_t;

    entry_t           r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    state_t           r_state;
    state_t           w_state_next;
    logic [31:0]      r_res_data;
    logic [TAG_W-1:0] r_res_tag;

    logic   w_full;
    logic   w_empty;
    logic   w_push;
    logic   w_pop;
    logic   w_res_valid;
    entry_t w_head;
    entry_t w_wr_entry;

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_res_valid = (r_state == ST_HOLD);
    assign w_push      = bus.cmd_valid && !w_full;
    assign w_pop       = !w_empty && (!w_res_valid || bus.res_ready);
    assign w_head      = r_mem[r_rd_ptr];

    assign w_wr_entry = '{data:   bus.cmd_data,
                          amount: bus.cmd_amount,
                          dir:    bus.cmd_dir,
                          typ:    bus.cmd_type,
                          tag:    bus.cmd_tag};

    assign bus.cmd_ready = !w_full;
    assign bus.res_valid = w_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_tag   = r_res_tag;
    assign count         = r_count;

    // Storage needs no reset: the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Shifter inputs come straight from the FIFO head; quiet zeros when nothing is queued.
    always_comb begin
        sh_data_in         = '0;
        sh_shift_amount    = '0;
        sh_shift_direction = 1'b0;
        sh_shift_type      = 1'b0;
        if (!w_empty) begin
            sh_data_in         = w_head.data;
            sh_shift_amount    = w_head.amount;
            sh_shift_direction = w_head.dir;
            sh_shift_type      = w_head.typ;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_pop) w_state_next = ST_HOLD;
            ST_HOLD:  if (!w_pop && bus.res_ready) w_state_next = ST_EMPTY;
            default:  w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_res_data <= '0;
            r_res_tag  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                r_res_data <= sh_data_out;
                r_res_tag  <= w_head.tag;
            end
        end
    end

`ifdef SHIFT_STATS_EN
    logic [15:0] r_stat_issued;
    logic [15:0] r_stat_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_issued <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (w_pop && r_stat_issued != 16'hFFFF)
                r_stat_issued <= r_stat_issued + 16'd1;
            if (w_res_valid && !bus.res_ready && r_stat_stall != 16'hFFFF)
                r_stat_stall <= r_stat_stall + 16'd1;
        end
    end

    assign stat_issued = r_stat_issued;
    assign stat_stall  = r_stat_stall;
`endif
endmodule

// File: tb/tb_shift_cmd_stage.sv
// Self-checking bench for shift_cmd_stage: vector table, scoreboard and multi-cycle sequences.
// A behavioural Shifter32 stand-in drives sh_data_out from the sh_* outputs.
module tb_shift_cmd_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] sh_data_in;
    logic [4:0]  sh_shift_amount;
    logic        sh_shift_direction;
    logic        sh_shift_type;
    logic [31:0] sh_data_out;
    logic [2:0]  count;
`ifdef SHIFT_STATS_EN
    logic [15:0] stat_issued;
    logic [15:0] stat_stall;
`endif

    shift_cmd_stage_if #(.TAG_W(4)) bus ();

    shift_cmd_stage #(.DEPTH(4), .TAG_W(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .bus                (bus.slave),
        .sh_data_in         (sh_data_in),
        .sh_shift_amount    (sh_shift_amount),
        .sh_shift_direction (sh_shift_direction),
        .sh_shift_type      (sh_shift_type),
        .sh_data_out        (sh_data_out),
        .count              (count)
`ifdef SHIFT_STATS_EN
        ,
        .stat_issued        (stat_issued),
        .stat_stall         (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        if (!sh_shift_direction)
            sh_data_out = sh_data_in << sh_shift_amount;
        else if (sh_shift_type)
            sh_data_out = 32'($signed(sh_data_in) >>> sh_shift_amount);
        else
            sh_data_out = sh_data_in >> sh_shift_amount;
    end

    typedef struct {
        logic [31:0] data;
        logic [4:0]  amount;
        logic        dir;
        logic        typ;
        logic [3:0]  tag;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
    } exp_t;

    vec_t        vecs [10];
    exp_t        sb [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_results = 0;
    int          stall_cnt = 0;
    logic [31:0] drv_exp = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] a,
                         input logic dir, input logic typ, input logic [3:0] tag,
                         input logic [31:0] exp);
        bus.cmd_valid  = v;
        bus.cmd_data   = d;
        bus.cmd_amount = a;
        bus.cmd_dir    = dir;
        bus.cmd_type   = typ;
        bus.cmd_tag    = tag;
        drv_exp        = exp;
    endtask

    // One clock: record accepted commands, compare consumed results, then advance.
    task automatic tick(output bit pushed);
        exp_t e;
        #1;
        pushed = bus.cmd_valid && bus.cmd_ready;
        if (pushed) begin
            e.data = drv_exp;
            e.tag  = bus.cmd_tag;
            sb.push_back(e);
        end
        if (bus.res_valid && bus.res_ready) begin
            n_results++;
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_result: got data 0x%08h tag %0d with empty scoreboard",
                         bus.res_data, bus.res_tag);
            end else begin
                e = sb.pop_front();
                check("res_data", bus.res_data, e.data);
                check("res_tag", 32'(bus.res_tag), 32'(e.tag));
                $display("result data=0x%08h tag=%0d", bus.res_data, bus.res_tag);
            end
        end
        if (bus.res_valid && !bus.res_ready) stall_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        stall_cnt = 0;
    endtask

    initial begin
        bit p;
        int budget;
        int idx;
        int base;

        vecs[0] = '{32'hA5A5A5A5,  5'd4, 1'b0, 1'b0, 4'd1,  32'h5A5A5A50};
        vecs[1] = '{32'hA5A5A5A5,  5'd8, 1'b1, 1'b0, 4'd2,  32'h00A5A5A5};
        vecs[2] = '{32'hF0000000,  5'd4, 1'b1, 1'b1, 4'd3,  32'hFF000000};
        vecs[3] = '{32'h12345678,  5'd0, 1'b0, 1'b0, 4'd4,  32'h12345678};
        vecs[4] = '{32'h80000000, 5'd31, 1'b1, 1'b1, 4'd5,  32'hFFFFFFFF};
        vecs[5] = '{32'h80000000, 5'd31, 1'b1, 1'b0, 4'd6,  32'h00000001};
        vecs[6] = '{32'h00000001, 5'd31, 1'b0, 1'b0, 4'd7,  32'h80000000};
        vecs[7] = '{32'h7FFFFFFF,  5'd1, 1'b1, 1'b1, 4'd8,  32'h3FFFFFFF};
        vecs[8] = '{32'hDEADBEEF, 5'd16, 1'b0, 1'b1, 4'd9,  32'hBEEF0000};
        vecs[9] = '{32'hDEADBEEF, 5'd12, 1'b1, 1'b0, 4'd10, 32'h000DEADB};

        drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        bus.res_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        check("reset_count", 32'(count), 32'd0);
        check("reset_res_valid", 32'(bus.res_valid), 32'd0);
        check("reset_res_data", bus.res_data, 32'd0);
        check("reset_res_tag", 32'(bus.res_tag), 32'd0);
        check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("empty_sh_data_in", sh_data_in, 32'd0);

        // Single command latency: head after push edge, result one edge later.
        drive(1'b1, vecs[0].data, vecs[0].amount, vecs[0].dir, vecs[0].typ, vecs[0].tag, vecs[0].exp);
        tick(p);
        bus.cmd_valid = 1'b0;
        check("lat_pushed", 32'(p), 32'd1);
        check("lat_count1", 32'(count), 32'd1);
        check("lat_res_valid_early", 32'(bus.res_valid), 32'd0);
        check("lat_sh_data_in", sh_data_in, 32'hA5A5A5A5);
        check("lat_sh_amount", 32'(sh_shift_amount), 32'd4);
        tick(p);
        check("lat_res_valid", 32'(bus.res_valid), 32'd1);
        check("lat_res_data", bus.res_data, 32'h5A5A5A50);
        check("lat_res_tag", 32'(bus.res_tag), 32'd1);
        tick(p);
        check("lat_res_valid_fall", 32'(bus.res_valid), 32'd0);
        check("lat_count0", 32'(count), 32'd0);

        // Vector table streamed back to back: one result per cycle.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].data, vecs[i].amount, vecs[i].dir, vecs[i].typ, vecs[i].tag, vecs[i].exp);
            tick(p);
            check("stream_accept", 32'(p), 32'd1);
        end
        bus.cmd_valid = 1'b0;
        tick(p);
        tick(p);
        check("stream_sb_empty", 32'(sb.size()), 32'd0);
        check("stream_res_valid", 32'(bus.res_valid), 32'd0);

        // Backpressure and full.
        do_reset();
        bus.res_ready = 1'b0;
        base = n_results;
        for (int t = 0; t < 5; t++) begin
            drive(1'b1, 32'h11111111 * 32'(t), 5'(t), 1'b0, 1'b0, 4'(t),
                  (32'h11111111 * 32'(t)) << t);
            budget = 0;
            p = 1'b0;
            while (!p && budget < 10) begin
                tick(p);
                budget++;
            end
            check("bp_push_accepted", 32'(p), 32'd1);
        end
        check("bp_count_full", 32'(count), 32'd4);
        check("bp_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
        check("bp_res_valid", 32'(bus.res_valid), 32'd1);
        drive(1'b1, 32'hCAFEF00D, 5'd1, 1'b0, 1'b0, 4'd15, 32'h0);
        for (int k = 0; k < 2; k++) begin
            tick(p);
            check("bp_no_push_full", 32'(p), 32'd0);
            check("bp_count_hold", 32'(count), 32'd4);
            check("bp_res_tag_hold", 32'(bus.res_tag), 32'd0);
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        budget = 0;
        while ((sb.size() != 0 || bus.res_valid) && budget < 20) begin
            tick(p);
            budget++;
        end
        check("bp_drain_done", 32'(budget < 20), 32'd1);
        check("bp_results", 32'(n_results - base), 32'd5);
        check("bp_count_zero", 32'(count), 32'd0);
        check("bp_res_valid_fall", 32'(bus.res_valid), 32'd0);
`ifdef SHIFT_STATS_EN
        check("stat_issued", 32'(stat_issued), 32'd5);
        check("stat_stall", 32'(stat_stall), 32'(stall_cnt));
`endif

        // Wrap-around with res_ready toggling every cycle.
        do_reset();
        bus.res_ready = 1'b0;
        base = n_results;
        idx = 0;
        budget = 0;
        while ((idx < 10 || sb.size() != 0 || bus.res_valid) && budget < 100) begin
            drive(idx < 10, 32'h1, 5'(idx), 1'b0, 1'b0, 4'(idx), 32'h1 << idx);
            bus.res_ready = ~bus.res_ready;
            tick(p);
            if (p) idx++;
            budget++;
        end
        bus.cmd_valid = 1'b0;
        check("wrap_done", 32'(budget < 100), 32'd1);
        check("wrap_results", 32'(n_results - base), 32'd10);
        check("wrap_sb_empty", 32'(sb.size()), 32'd0);

        // Reset in the middle of traffic.
        do_reset();
        bus.res_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            drive(1'b1, 32'h0000_0100, 5'(t), 1'b1, 1'b0, 4'(t + 8), 32'h0000_0100 >> t);
            tick(p);
        end
        bus.cmd_valid = 1'b0;
        check("mid_count3", 32'(count), 32'd3);
        check("mid_res_valid", 32'(bus.res_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("mid_rst_res_data", bus.res_data, 32'd0);
        check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        bus.res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(p);
            check("mid_no_stale", 32'(bus.res_valid), 32'd0);
        end
        drive(1'b1, 32'h0000_00F0, 5'd4, 1'b1, 1'b0, 4'd12, 32'h0000_000F);
        tick(p);
        bus.cmd_valid = 1'b0;
        tick(p);
        tick(p);
        check("post_rst_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/shift_cmd_stage.md
Name: shift_cmd_stage

Overview:
Command-buffering stage wrapped around the existing combinational 32-bit shifter (Shifter32). Accepts shift commands over a valid/ready interface and queues them in a small FIFO. Drives the shifter from the FIFO head, registers the shifter result with its tag, and presents it on a valid/ready result interface. Provides the pipeline boundary the shifter lacks, so the shifter sits between two register stages.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, minimum 2.
TAG_W, 4, width of the opaque command tag carried alongside each command.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  stage can accept a command; equals !full.
cmd_data  input  32  operand.
cmd_amount  input  5  shift amount 0..31.
cmd_dir  input  1  0 = left, 1 = right.
cmd_type  input  1  0 = logical, 1 = arithmetic (right only).
cmd_tag  input  TAG_W  returned unchanged with the result.
sh_data_in  output  32  to shifter data_in.
sh_shift_amount  output  5  to shifter shift_amount.
sh_shift_direction  output  1  to shifter shift_direction.
sh_shift_type  output  1  to shifter shift_type.
sh_data_out  input  32  from shifter data_out.
res_valid  output  1  result register holds a result.
res_ready  input  1  consumer accepts the result.
res_data  output  32  registered shift result.
res_tag  output  TAG_W  tag of the result.
count  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset: wr/rd pointers = 0, count = 0, res_valid = 0, res_data = 0, res_tag = 0. Reset has priority over all events, including a mid-flight command or a held result. Queued entries are discarded.
- push = cmd_valid && cmd_ready. The command fields are written at the write pointer. The pointer wraps modulo DEPTH.
- Full: count == DEPTH, so cmd_ready = 0 and no push occurs. There is no same-cycle bypass of pop into a push when full.
- The sh_* outputs are driven combinationally from the FIFO head entry. When the FIFO is empty, all sh_* outputs are 0.
- Result register has two states: EMPTY (res_valid = 0) and HOLD (res_valid = 1).
- can_load = (count != 0) && (!res_valid || res_ready).
- pop = can_load. On pop, at the clock edge: res_data <= sh_data_out, res_tag <= head tag, res_valid <= 1. The read pointer advances and wraps.
- In HOLD with res_ready = 1 and count = 0: res_valid <= 0 (to EMPTY).
- In HOLD with res_ready = 0: res_data, res_tag and res_valid are held stable. The FIFO head is not popped.
- count updates on every edge: +1 on push only, −1 on pop only, unchanged on push and pop together.
- Latency: a command pushed at edge k is at the head after edge k. Its result is valid after edge k+1 if the result path is free. Throughput is 1 command/cycle with res_ready held high.
- Results emerge in command order. Data is never dropped or duplicated.
- Command fields pass to the shifter unmodified. Left shifts with cmd_type = 1 are left to the shifter's semantics. Amount 0 yields data unchanged.

Optional Feature:
SHIFT_STATS_EN. When defined, adds two outputs:
- stat_issued (16 bits): number of pops, saturating at 0xFFFF.
- stat_stall (16 bits): cycles with res_valid && !res_ready, saturating at 0xFFFF.
Both counters clear on rst. When the macro is undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Bench instantiates Shifter32 connected to the sh_* ports.
- Left logical shift: push data 0xA5A5A5A5, amount 4, dir 0, tag 1, with res_ready = 1. Result: res_valid rises 2 edges after the push, res_data 0x5A5A5A50, res_tag 1.
- Back-to-back commands: push (0xA5A5A5A5, 8, right, logical, tag 2) then (0xF0000000, 4, right, arithmetic, tag 3) on consecutive cycles. Results on consecutive cycles: 0x00A5A5A5/tag 2, then 0xFF000000/tag 3.
- Backpressure and full: hold res_ready = 0 and push 5 commands (tags 0..4). First result is latched. count reaches 4, then cmd_ready goes 0 with count = 4. Release res_ready: 5 results emerge in tag order 0..4. count returns to 0 and res_valid falls.
- Wrap-around: stream 10 commands (amount = i, left, data 0x1) with res_ready toggling every cycle. Each result equals 1<<i in order. Pointers wrap twice without loss.
- Reset mid-operation: with 3 commands queued and res_valid = 1, assert rst for 1 cycle. Next cycle count = 0, res_valid = 0, res_data = 0, cmd_ready = 1. No stale results appear afterwards.
- With SHIFT_STATS_EN defined: in the backpressure scenario, stat_issued = 5 at the end, and stat_stall equals the cycles res_ready was held low while res_valid = 1.
